// File: rtl/pc_unit_pkg.sv
// Shared encodings for the program-counter unit: operations, branch conditions
// and the bit positions of the {Z, N, V} status word.
package pc_unit_pkg;

   typedef enum logic [2:0] {
      OP_HOLD  = 3'b000,
      OP_NEXT  = 3'b001,
      OP_BR    = 3'b010,
      OP_JR    = 3'b011,
      OP_CALL  = 3'b100,
      OP_CALLR = 3'b101,
      OP_RET   = 3'b110,
      OP_RSVD  = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      COND_AL  = 3'b000,
      COND_EQ  = 3'b001,
      COND_NE  = 3'b010,
      COND_LT  = 3'b011,
      COND_LE  = 3'b100,
      COND_NV5 = 3'b101,
      COND_NV6 = 3'b110,
      COND_AL7 = 3'b111
   } cond_e;

   localparam int STATUS_Z = 2;
   localparam int STATUS_N = 1;
   localparam int STATUS_V = 0;

   function automatic logic condTrue(input logic [2:0] cond, input logic [2:0] status);
      logic z;
      logic lt;
      logic res;
      z  = status[STATUS_Z];
      lt = status[STATUS_N] ^ status[STATUS_V];
      case (cond)
         COND_AL, COND_AL7: res = 1'b1;
         COND_EQ:           res = z;
         COND_NE:           res = ~z;
         COND_LT:           res = lt;
         COND_LE:           res = z | lt;
         default:           res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Controller-facing bundle of the program-counter unit; the controller drives
// through the master modport and pc_unit consumes it through the slave modport.
interface pc_unit_if #(
   parameter int PC_W  = 8,
   parameter int CNT_W = 3
);
   logic            stall;
   logic [2:0]      op;
   logic [2:0]      cond;
   logic [2:0]      status;
   logic [PC_W-1:0] offset;
   logic [PC_W-1:0] rtarget;
   logic            clr_err;
   logic [PC_W-1:0] pc;
   logic            taken;
   logic [CNT_W-1:0] ras_count;
   logic            ras_full;
   logic            ras_empty;
   logic            ras_err;

   modport master (
      output stall, op, cond, status, offset, rtarget, clr_err,
      input  pc, taken, ras_count, ras_full, ras_empty, ras_err
   );

   modport slave (
      input  stall, op, cond, status, offset, rtarget, clr_err,
      output pc, taken, ras_count, ras_full, ras_empty, ras_err
   );
endinterface

// File: rtl/pc_unit_return_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry, an
// empty pop leaves state alone; both raise a sticky error flag.
module return_stack #(
   parameter  int W     = 8,
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_clr,
   input  logic [W-1:0]     i_din,
   output logic [W-1:0]     o_dout,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_err
);
   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_top;
   logic [CNT_W-1:0] r_count;
   logic             r_err;
   logic [PTR_W-1:0] w_topInc;
   logic [PTR_W-1:0] w_topDec;
   logic             w_full;
   logic             w_empty;
   logic             w_overflow;
   logic             w_underflow;

   assign w_full      = (r_count == CNT_W'(DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_topInc    = (r_top == PTR_W'(DEPTH - 1)) ? '0 : r_top + PTR_W'(1);
   assign w_topDec    = (r_top == '0) ? PTR_W'(DEPTH - 1) : r_top - PTR_W'(1);
   assign w_overflow  = i_push & w_full;
   assign w_underflow = i_pop & w_empty;

   assign o_dout  = r_mem[w_topDec];
   assign o_count = r_count;
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_err   = r_err;

   // When full, r_top already points at the oldest entry, so a push overwrites it.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_top] <= i_din;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_top   <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         if (i_push) begin
            r_top <= w_topInc;
            if (!w_full) begin
               r_count <= r_count + CNT_W'(1);
            end
         end else if (i_pop && !w_empty) begin
            r_top   <= w_topDec;
            r_count <= r_count - CNT_W'(1);
         end
         if (w_overflow || w_underflow) begin
            r_err <= 1'b1;
         end else if (i_clr) begin
            r_err <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC select, conditional branches, indirect jumps.
// The return-address stack exists only when PC_UNIT_RAS_EN is defined.
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int              PC_W      = 8,
   parameter int              RAS_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_PC  = '0
) (
   input  logic     clk,
   input  logic     reset,
   pc_unit_if.slave bus
);
   op_e             w_op;
   logic            w_condTrue;
   logic            w_taken;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pcNext;
   logic [PC_W-1:0] w_pcInc;
   logic [PC_W-1:0] w_pcRel;

   assign w_op       = op_e'(bus.op);
   assign w_condTrue = condTrue(bus.cond, bus.status);
   assign w_pcInc    = r_pc + PC_W'(1);
   assign w_pcRel    = r_pc + bus.offset;

`ifdef PC_UNIT_RAS_EN
   logic            w_push;
   logic            w_pop;
   logic            w_clr;
   logic            w_rasEmpty;
   logic [PC_W-1:0] w_rasDout;
`endif

   // Stall freezes everything, so all redirects and stack traffic sit under !stall.
   always_comb begin
      w_pcNext = r_pc;
      w_taken  = 1'b0;
`ifdef PC_UNIT_RAS_EN
      w_push   = 1'b0;
      w_pop    = 1'b0;
`endif
      if (!bus.stall) begin
         case (w_op)
            OP_NEXT: w_pcNext = w_pcInc;
            OP_BR: begin
               w_taken  = w_condTrue;
               w_pcNext = w_condTrue ? w_pcRel : w_pcInc;
            end
            OP_JR: begin
               w_taken  = 1'b1;
               w_pcNext = bus.rtarget;
            end
            OP_CALL: begin
               w_taken  = 1'b1;
               w_pcNext = w_pcRel;
`ifdef PC_UNIT_RAS_EN
               w_push   = 1'b1;
`endif
            end
            OP_CALLR: begin
               w_taken  = 1'b1;
               w_pcNext = bus.rtarget;
`ifdef PC_UNIT_RAS_EN
               w_push   = 1'b1;
`endif
            end
            OP_RET: begin
`ifdef PC_UNIT_RAS_EN
               w_pop    = 1'b1;
               w_taken  = ~w_rasEmpty;
               w_pcNext = w_rasEmpty ? w_pcInc : w_rasDout;
`else
               w_taken  = 1'b1;
               w_pcNext = bus.rtarget;
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_pcNext;
      end
   end

   assign bus.pc    = r_pc;
   assign bus.taken = w_taken;

`ifdef PC_UNIT_RAS_EN
   assign w_clr = bus.clr_err & ~bus.stall;

   return_stack #(
      .W     (PC_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clr   (w_clr),
      .i_din   (w_pcInc),
      .o_dout  (w_rasDout),
      .o_count (bus.ras_count),
      .o_full  (bus.ras_full),
      .o_empty (w_rasEmpty),
      .o_err   (bus.ras_err)
   );

   assign bus.ras_empty = w_rasEmpty;
`else
   logic w_unusedClr;
   assign w_unusedClr   = bus.clr_err;
   assign bus.ras_count = '0;
   assign bus.ras_full  = 1'b0;
   assign bus.ras_empty = 1'b1;
   assign bus.ras_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: spec-derived vector table, hand sequences for
// stack overflow/underflow, stall and async reset, then random ops against a queue model.
module tb_pc_unit;
   import pc_unit_pkg::*;

   localparam int         PC_W      = 8;
   localparam int         RAS_DEPTH = 4;
   localparam int         CNT_W     = 3;
   localparam logic [7:0] RESET_PC  = 8'h00;
`ifdef PC_UNIT_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b0;

   pc_unit_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

   pc_unit #(
      .PC_W      (PC_W),
      .RAS_DEPTH (RAS_DEPTH),
      .RESET_PC  (RESET_PC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int         nChecks = 0;
   int         nFail   = 0;
   logic       lastTaken;
   logic [7:0] mPc;
   logic [7:0] mStack[$];
   logic       mErr;
   logic [7:0] pcBefore;

   typedef struct {
      logic [2:0] op;
      logic [2:0] cond;
      logic [2:0] status;
      logic [7:0] offset;
      logic [7:0] rtarget;
      logic [7:0] expPc;
      logic       expTaken;
      int         expCnt;
      string      name;
   } vec_t;

   vec_t vecs[$];

   // Reference model: the stack is a plain queue, oldest entry at the front.
   function automatic bit mCondTrue(input logic [2:0] c, input logic [2:0] s);
      bit z;
      bit lt;
      z  = s[2];
      lt = s[1] != s[0];
      case (c)
         3'd0, 3'd7: return 1'b1;
         3'd1:       return z;
         3'd2:       return !z;
         3'd3:       return lt;
         3'd4:       return z || lt;
         default:    return 1'b0;
      endcase
   endfunction

   function automatic bit mTaken(input logic [2:0] o, input logic [2:0] c, input logic [2:0] s,
                                 input logic st);
      if (st) return 1'b0;
      case (o)
         3'd2:             return mCondTrue(c, s);
         3'd3, 3'd4, 3'd5: return 1'b1;
         3'd6:             return RAS_EN ? (mStack.size() != 0) : 1'b1;
         default:          return 1'b0;
      endcase
   endfunction

   function automatic void mReset();
      mPc = RESET_PC;
      mStack.delete();
      mErr = 1'b0;
   endfunction

   function automatic void mStep(input logic [2:0] o, input logic [2:0] c, input logic [2:0] s,
                                 input logic [7:0] off, input logic [7:0] rt,
                                 input logic st, input logic clr);
      bit newErr;
      newErr = 1'b0;
      if (st) return;
      case (o)
         3'd1: mPc = mPc + 8'd1;
         3'd2: mPc = mCondTrue(c, s) ? mPc + off : mPc + 8'd1;
         3'd3: mPc = rt;
         3'd4, 3'd5: begin
            if (RAS_EN) begin
               if (mStack.size() == RAS_DEPTH) begin
                  void'(mStack.pop_front());
                  newErr = 1'b1;
               end
               mStack.push_back(mPc + 8'd1);
            end
            mPc = (o == 3'd4) ? mPc + off : rt;
         end
         3'd6: begin
            if (!RAS_EN) mPc = rt;
            else if (mStack.size() == 0) begin
               mPc    = mPc + 8'd1;
               newErr = 1'b1;
            end else mPc = mStack.pop_back();
         end
         default: ;
      endcase
      if (RAS_EN) mErr = newErr ? 1'b1 : (clr ? 1'b0 : mErr);
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      nChecks++;
      if (actual != expected) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, " pc"}, bus.pc, mPc);
      checkOutput({tag, " ras_count"}, bus.ras_count, RAS_EN ? mStack.size() : 0);
      checkOutput({tag, " ras_full"}, bus.ras_full, RAS_EN && (mStack.size() == RAS_DEPTH));
      checkOutput({tag, " ras_empty"}, bus.ras_empty, !RAS_EN || (mStack.size() == 0));
      checkOutput({tag, " ras_err"}, bus.ras_err, RAS_EN && mErr);
   endtask

   task automatic driveInputs(input logic [2:0] o, input logic [2:0] c, input logic [2:0] s,
                              input logic [7:0] off, input logic [7:0] rt,
                              input logic st, input logic clr);
      bus.op      = o;
      bus.cond    = c;
      bus.status  = s;
      bus.offset  = off;
      bus.rtarget = rt;
      bus.stall   = st;
      bus.clr_err = clr;
   endtask

   // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
   task automatic applyStimulus(input logic [2:0] o, input logic [2:0] c, input logic [2:0] s,
                                input logic [7:0] off, input logic [7:0] rt,
                                input logic st, input logic clr, input string tag);
      driveInputs(o, c, s, off, rt, st, clr);
      #1;
      lastTaken = bus.taken;
      checkOutput({tag, " taken"}, lastTaken, mTaken(o, c, s, st));
      @(posedge clk);
      #1;
      mStep(o, c, s, off, rt, st, clr);
      checkState(tag);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      driveInputs(OP_HOLD, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
      mReset();
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk);
      #1;
      checkState("reset");
      checkOutput("reset pc value", bus.pc, 8'h00);

      vecs.push_back('{OP_NEXT,  3'b000, 3'b000, 8'h00, 8'h00, 8'h01, 1'b0, 0, "next1"});
      vecs.push_back('{OP_NEXT,  3'b000, 3'b000, 8'h00, 8'h00, 8'h02, 1'b0, 0, "next2"});
      vecs.push_back('{OP_NEXT,  3'b000, 3'b000, 8'h00, 8'h00, 8'h03, 1'b0, 0, "next3"});
      vecs.push_back('{OP_JR,    3'b000, 3'b000, 8'h00, 8'h10, 8'h10, 1'b1, 0, "jr10a"});
      vecs.push_back('{OP_BR,    3'b001, 3'b100, 8'hFC, 8'h00, 8'h0C, 1'b1, 0, "brEqZ"});
      vecs.push_back('{OP_JR,    3'b000, 3'b000, 8'h00, 8'h10, 8'h10, 1'b1, 0, "jr10b"});
      vecs.push_back('{OP_BR,    3'b011, 3'b011, 8'hFC, 8'h00, 8'h11, 1'b0, 0, "brLtNV"});
      vecs.push_back('{OP_JR,    3'b000, 3'b000, 8'h00, 8'h20, 8'h20, 1'b1, 0, "jr20"});
      vecs.push_back('{OP_CALL,  3'b000, 3'b000, 8'h10, 8'h00, 8'h30, 1'b1, 1, "call1"});
      vecs.push_back('{OP_CALL,  3'b000, 3'b000, 8'h10, 8'h00, 8'h40, 1'b1, 2, "call2"});
      vecs.push_back('{OP_RET,   3'b000, 3'b000, 8'h00, 8'h31, 8'h31, 1'b1, 1, "ret1"});
      vecs.push_back('{OP_RET,   3'b000, 3'b000, 8'h00, 8'h21, 8'h21, 1'b1, 0, "ret2"});
      vecs.push_back('{OP_JR,    3'b000, 3'b000, 8'h00, 8'hFF, 8'hFF, 1'b1, 0, "jrFF"});
      vecs.push_back('{OP_NEXT,  3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 0, "wrap"});
      vecs.push_back('{OP_BR,    3'b010, 3'b000, 8'h05, 8'h00, 8'h05, 1'b1, 0, "brNe"});
      vecs.push_back('{OP_BR,    3'b100, 3'b010, 8'h10, 8'h00, 8'h15, 1'b1, 0, "brLe"});
      vecs.push_back('{OP_BR,    3'b101, 3'b111, 8'h10, 8'h00, 8'h16, 1'b0, 0, "brNv5"});
      vecs.push_back('{OP_BR,    3'b111, 3'b000, 8'h02, 8'h00, 8'h18, 1'b1, 0, "brAl7"});
      vecs.push_back('{OP_HOLD,  3'b000, 3'b000, 8'h07, 8'h77, 8'h18, 1'b0, 0, "hold"});
      vecs.push_back('{OP_RSVD,  3'b000, 3'b000, 8'h07, 8'h77, 8'h18, 1'b0, 0, "rsvd"});

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].op, vecs[i].cond, vecs[i].status, vecs[i].offset,
                       vecs[i].rtarget, 1'b0, 1'b0, vecs[i].name);
         checkOutput({vecs[i].name, " tbl taken"}, lastTaken, vecs[i].expTaken);
         checkOutput({vecs[i].name, " tbl pc"}, bus.pc, vecs[i].expPc);
         checkOutput({vecs[i].name, " tbl cnt"}, bus.ras_count, RAS_EN ? vecs[i].expCnt : 0);
      end

      // Overflow then underflow: five calls, five returns from 0x80.
      applyStimulus(OP_JR, 3'd0, 3'd0, 8'h00, 8'h80, 1'b0, 1'b0, "ovf jr");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(OP_CALL, 3'd0, 3'd0, 8'h01, 8'h00, 1'b0, 1'b0, "ovf call");
      end
      checkOutput("ovf count", bus.ras_count, RAS_EN ? 4 : 0);
      checkOutput("ovf full", bus.ras_full, RAS_EN);
      checkOutput("ovf err", bus.ras_err, RAS_EN);
      applyStimulus(OP_RET, 3'd0, 3'd0, 8'h00, 8'h85, 1'b0, 1'b0, "unf ret1");
      applyStimulus(OP_RET, 3'd0, 3'd0, 8'h00, 8'h84, 1'b0, 1'b0, "unf ret2");
      applyStimulus(OP_RET, 3'd0, 3'd0, 8'h00, 8'h83, 1'b0, 1'b0, "unf ret3");
      applyStimulus(OP_RET, 3'd0, 3'd0, 8'h00, 8'h82, 1'b0, 1'b0, "unf ret4");
      checkOutput("unf ret4 pc", bus.pc, 8'h82);
      applyStimulus(OP_RET, 3'd0, 3'd0, 8'h00, 8'h83, 1'b0, 1'b0, "unf ret5");
      checkOutput("unf ret5 pc", bus.pc, 8'h83);
      checkOutput("unf ret5 empty", bus.ras_empty, 1);
      checkOutput("unf ret5 err", bus.ras_err, RAS_EN);
      applyStimulus(OP_HOLD, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, "clr");
      checkOutput("clr err", bus.ras_err, 0);
      applyStimulus(OP_RET, 3'd0, 3'd0, 8'h00, 8'h40, 1'b0, 1'b1, "clr vs err");
      checkOutput("clr vs err err", bus.ras_err, RAS_EN);

      // Stall blocks the call, the push and the error clear.
      applyStimulus(OP_CALL, 3'd0, 3'd0, 8'h10, 8'h00, 1'b0, 1'b0, "pre stall call1");
      applyStimulus(OP_CALL, 3'd0, 3'd0, 8'h10, 8'h00, 1'b0, 1'b0, "pre stall call2");
      pcBefore = mPc;
      applyStimulus(OP_CALLR, 3'd0, 3'd0, 8'h00, 8'h55, 1'b1, 1'b1, "stall callr");
      checkOutput("stall taken", lastTaken, 0);
      checkOutput("stall pc", bus.pc, pcBefore);
      checkOutput("stall count", bus.ras_count, RAS_EN ? 2 : 0);
      checkOutput("stall err", bus.ras_err, RAS_EN);

      // Asynchronous reset between edges, then release it while stalled.
      driveInputs(OP_NEXT, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1;
      mReset();
      checkOutput("async pc", bus.pc, RESET_PC);
      checkOutput("async count", bus.ras_count, 0);
      checkOutput("async empty", bus.ras_empty, 1);
      checkOutput("async err", bus.ras_err, 0);
      bus.stall = 1'b1;
      @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk);
      #1;
      checkState("reset mid stall");
      applyStimulus(OP_NEXT, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, "resume");
      checkOutput("resume pc", bus.pc, 8'h01);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the RISC machine: next-PC selection, conditional PC-relative branches, register-indirect jumps, and a hardware return-address stack (RAS) for call/return. It replaces the fixed 8-bit PC register, PC-next multiplexers and combinational branch decode in the datapath. It sits between the controller FSM (which issues `op`), the status register, and the memory address multiplexer (which consumes `pc`).

## Interface

Parameters:
- `PC_W`, 8: PC and target width in bits.
- `RAS_DEPTH`, 4: return-stack entries; must be ≥ 2.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk` input, 1 bit: clock. All state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `stall` input, 1 bit: when 1, all state is held and `op` is ignored.
- `op` input, 3 bits: operation for this cycle (encodings under Operation).
- `cond` input, 3 bits: branch condition code.
- `status` input, 3 bits: {Z, N, V} from the status register.
- `offset` input, PC_W bits: sign-extended relative displacement.
- `rtarget` input, PC_W bits: register-indirect target.
- `clr_err` input, 1 bit: synchronous clear of `ras_err`.
- `pc` output, PC_W bits: current PC.
- `taken` output, 1 bit: combinational; 1 when the current `op` redirects the PC.
- `ras_count` output, clog2(RAS_DEPTH+1) bits: number of valid stack entries.
- `ras_full` output, 1 bit: `ras_count == RAS_DEPTH`.
- `ras_empty` output, 1 bit: `ras_count == 0`.
- `ras_err` output, 1 bit: sticky overflow/underflow flag.

## Operation

- `op` encodings:
  - HOLD 000: pc unchanged.
  - NEXT 001: pc+1.
  - BR 010: if condition is true, pc+offset; else pc+1.
  - JR 011: rtarget.
  - CALL 100: push pc+1; pc+offset.
  - CALLR 101: push pc+1; rtarget.
  - RET 110: pop; pc = popped value.
  - 111: reserved; behaves as HOLD.
- Condition codes (true when):
  - 000 always
  - 001 Z
  - 010 !Z
  - 011 N≠V
  - 100 Z | (N≠V)
  - 111 always
  - 101 and 110 never
- `taken` is 1 for BR with a true condition, and for JR, CALL, CALLR, and RET with a non-empty stack. It is 0 when `stall` is 1.
- All PC arithmetic is modulo 2^PC_W. `offset` is added as two's complement, so 0xFF+1 wraps to 0x00 and pc+0xFE equals pc−2.
- RAS is a circular buffer.
  - Push when full overwrites the oldest entry, `ras_count` stays at RAS_DEPTH, and `ras_err` is set.
  - RET when empty gives pc+1 (no redirect), `ras_count` stays at 0, and `ras_err` is set.
- `ras_err` is sticky until `clr_err` or reset. If `clr_err` coincides with a new error, set wins.

## Timing

- Reset (asynchronous, on the falling edge of `reset`):
  - `pc` = RESET_PC, `ras_count` = 0, `ras_empty` = 1, `ras_full` = 0, `ras_err` = 0.
  - Stack contents are don't-care.
- Latency: `op` presented in cycle n produces the new `pc` visible after edge n+1. Push and pop take effect on the same edge.
- `taken` is purely combinational from `op`, `cond`, `status`, `stall` and `ras_empty`. It has no registered delay.
- `status` is sampled in the same cycle as BR. The controller must hold `op` stable across the edge.
- A deassertion of `reset` mid-stall resumes at RESET_PC with the stack empty.
- `stall` has priority over `op`, and over `clr_err` as well.

## Configuration

- `PC_UNIT_RAS_EN` defined: the RAS is implemented as described above.
- `PC_UNIT_RAS_EN` undefined: no stack storage.
  - CALL behaves as BR with cond 000 (always).
  - CALLR behaves as JR.
  - RET behaves as JR, using `rtarget` as the link value.
  - `ras_count` = 0, `ras_empty` = 1, `ras_full` = 0, `ras_err` = 0 constantly; `clr_err` is ignored.

## Structure

- Shared package `pc_unit_pkg`: op encodings and condition-code encodings. The status bit order {Z, N, V} is also a shared constant in this package.
- Sub-module `return_stack`: parametrised by width and depth. It owns the circular pointer, the count, and overflow/underflow detection. The push, pop, data-in, data-out, full and empty interface is internal to `pc_unit`.
- The condition evaluation stays inline as combinational logic.

## Test plan

- Reset and step: reset low, then high with RESET_PC=0. Apply NEXT ×3 → pc = 0,1,2,3; stack empty, `ras_err` = 0.
- Branch conditions: pc=0x10, offset=0xFC.
  - BR cond 001 with Z=1 → `taken` = 1, pc = 0x0C.
  - BR cond 011 with N=1, V=1 → `taken` = 0, pc = 0x11.
- Call/return nesting: CALL from 0x20 (offset 0x10), then CALL from 0x30 (offset 0x10), then RET, RET → pc sequence 0x30, 0x40, 0x31, 0x21; `ras_count` = 1, 2, 1, 0.
- Overflow/underflow with RAS_DEPTH=4:
  - Five CALLs → `ras_full` = 1, `ras_err` = 1, count = 4. Five RETs → the fifth yields pc+1, `ras_empty` = 1.
  - `clr_err` → `ras_err` = 0.
- Stall and wrap: with `stall` = 1, issue CALLR rtarget=0x55 → pc and count unchanged, `taken` = 0. From pc=0xFF, NEXT → pc = 0x00.
- Asynchronous reset mid-operation: assert `reset` low between edges with count = 2 → pc = RESET_PC and count = 0 immediately, without waiting for a clock edge.
